// File: rtl/coin_input_conditioner_pkg.sv
// Shared definitions for the coin input conditioner: channel indices, default
// debounce parameters and the fixed-priority grant function.
package coin_input_conditioner_pkg;

  localparam int N_CH          = 3;
  localparam int CH_CANCEL     = 0;
  localparam int CH_DOLLAR     = 1;
  localparam int CH_FIFTY      = 2;
  localparam int DB_CYCLES_DEF = 16;
  localparam int CNT_W_DEF     = 5;

  // One-hot grant, cancel > dollar > fifty.
  function automatic logic [N_CH-1:0] prio_grant(input logic [N_CH-1:0] req);
    logic [N_CH-1:0] g;
    g = '0;
    if (req[CH_CANCEL])      g[CH_CANCEL] = 1'b1;
    else if (req[CH_DOLLAR]) g[CH_DOLLAR] = 1'b1;
    else if (req[CH_FIFTY])  g[CH_FIFTY]  = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/coin_input_conditioner_debounce_ch.sv
// One sensor channel: 2-flop synchroniser, stability counter, debounced level and
// a pending flag that is set on each accepted rising level and cleared by the arbiter.
module debounce_ch
  import coin_input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic clr_pend,
  output logic pend
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             w_accept;

  assign w_accept = (r_s2 != r_db) && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      // Any return of s2 to the debounced level restarts the stability count.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= '0;
        r_db  <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_pend <= (r_pend & ~clr_pend) | (w_accept & r_s2);
    end
  end

  assign pend = r_pend;

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces the three sensor lines and serialises their presses into registered,
// mutually exclusive 1-cycle pulses, gating coins with the FSM's insert_coin.
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic coin50_raw,
  input  logic coin100_raw,
  input  logic cancel_raw,
  input  logic insert_coin,
  output logic fifty,
  output logic dollar,
  output logic cancel,
  output logic coin_reject
);

  logic [N_CH-1:0] w_raw;
  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_grant;
  logic            r_fifty;
  logic            r_dollar;
  logic            r_cancel;
  logic            r_coin_reject;

  assign w_raw[CH_CANCEL] = cancel_raw;
  assign w_raw[CH_DOLLAR] = coin100_raw;
  assign w_raw[CH_FIFTY]  = coin50_raw;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .raw      (w_raw[gi]),
        .clr_pend (w_grant[gi]),
        .pend     (w_pend[gi])
      );
    end
  endgenerate

  // The grant also clears the winner's pend, so a granted event is always consumed.
  assign w_grant = prio_grant(w_pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifty       <= 1'b0;
      r_dollar      <= 1'b0;
      r_cancel      <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_cancel      <= w_grant[CH_CANCEL] & insert_coin;
      r_dollar      <= w_grant[CH_DOLLAR] & insert_coin;
      r_fifty       <= w_grant[CH_FIFTY]  & insert_coin;
      r_coin_reject <= (w_grant[CH_DOLLAR] | w_grant[CH_FIFTY]) & ~insert_coin;
    end
  end

  assign fifty       = r_fifty;
  assign dollar      = r_dollar;
  assign cancel      = r_cancel;
  assign coin_reject = r_coin_reject;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DB_CYCLES=4: press latency, bounce,
// arbitration order, insert_coin gating, async reset and long holds.
module tb_coin_input_conditioner;

  localparam logic [3:0] O_NONE   = 4'b0000;
  localparam logic [3:0] O_CANCEL = 4'b1000;
  localparam logic [3:0] O_DOLLAR = 4'b0100;
  localparam logic [3:0] O_FIFTY  = 4'b0010;
  localparam logic [3:0] O_REJ    = 4'b0001;

  logic clk         = 1'b0;
  logic rst         = 1'b1;
  logic coin50_raw  = 1'b0;
  logic coin100_raw = 1'b0;
  logic cancel_raw  = 1'b0;
  logic insert_coin = 1'b1;
  logic fifty;
  logic dollar;
  logic cancel;
  logic coin_reject;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coin_input_conditioner #(
    .DB_CYCLES (4),
    .CNT_W     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin50_raw  (coin50_raw),
    .coin100_raw (coin100_raw),
    .cancel_raw  (cancel_raw),
    .insert_coin (insert_coin),
    .fifty       (fifty),
    .dollar      (dollar),
    .cancel      (cancel),
    .coin_reject (coin_reject)
  );

  function automatic logic [3:0] outs();
    return {cancel, dollar, fifty, coin_reject};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges and OR together every output seen.
  task automatic tick_acc(input int n, output logic [3:0] acc);
    acc = O_NONE;
    repeat (n) begin
      tick();
      acc = acc | outs();
    end
  endtask

  task automatic release_all(input string tag);
    logic [3:0] acc;
    coin50_raw  = 1'b0;
    coin100_raw = 1'b0;
    cancel_raw  = 1'b0;
    tick_acc(12, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL %s_release_quiet: outputs seen %b expected %b", tag, acc, O_NONE);
    end
  endtask

  task automatic test_reset();
    logic [3:0] acc;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), O_NONE);
    end
    repeat (3) tick();
    rst = 1'b1;
    tick_acc(10, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL reset_idle: outputs seen %b expected %b", acc, O_NONE);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    logic [3:0] acc;
    insert_coin = 1'b1;
    coin50_raw  = 1'b1;
    tick_acc(6, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL clean_early: outputs seen %b expected %b", acc, O_NONE);
    end
    tick();
    checks++;
    if (outs() !== O_FIFTY) begin
      failures++;
      $display("FAIL clean_pulse_E6: got %b expected %b", outs(), O_FIFTY);
    end
    tick();
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL clean_pulse_end: got %b expected %b", outs(), O_NONE);
    end
    release_all("clean");
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    logic [3:0] acc;
    logic [3:0] acc2;
    coin100_raw = 1'b1;
    tick_acc(3, acc);
    coin100_raw = 1'b0;
    tick_acc(1, acc2);
    acc = acc | acc2;
    coin100_raw = 1'b1;
    tick_acc(6, acc2);
    acc = acc | acc2;
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL bounce_early: outputs seen %b expected %b", acc, O_NONE);
    end
    tick();
    checks++;
    if (outs() !== O_DOLLAR) begin
      failures++;
      $display("FAIL bounce_pulse: got %b expected %b", outs(), O_DOLLAR);
    end
    tick();
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL bounce_pulse_end: got %b expected %b", outs(), O_NONE);
    end
    release_all("bounce");
    $display("test_bounce done");
  endtask

  task automatic test_simultaneous();
    logic [3:0] acc;
    logic [3:0] exp_seq [4];
    exp_seq[0] = O_CANCEL;
    exp_seq[1] = O_DOLLAR;
    exp_seq[2] = O_FIFTY;
    exp_seq[3] = O_NONE;
    coin50_raw  = 1'b1;
    coin100_raw = 1'b1;
    cancel_raw  = 1'b1;
    tick_acc(6, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL simul_early: outputs seen %b expected %b", acc, O_NONE);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (outs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL simul_E%0d: got %b expected %b", 6 + i, outs(), exp_seq[i]);
      end
    end
    release_all("simul");
    $display("test_simultaneous done");
  endtask

  task automatic test_coin_while_vending();
    logic [3:0] acc;
    insert_coin = 1'b0;
    coin50_raw  = 1'b1;
    tick_acc(6, acc);
    tick();
    checks++;
    if ((acc | O_NONE) !== O_NONE || outs() !== O_REJ) begin
      failures++;
      $display("FAIL vend_reject50: early %b at_E6 %b expected %b then %b", acc, outs(), O_NONE, O_REJ);
    end
    tick();
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL vend_reject50_end: got %b expected %b", outs(), O_NONE);
    end
    release_all("vend50");
    coin100_raw = 1'b1;
    repeat (7) tick();
    checks++;
    if (outs() !== O_REJ) begin
      failures++;
      $display("FAIL vend_reject100: got %b expected %b", outs(), O_REJ);
    end
    release_all("vend100");
    cancel_raw = 1'b1;
    tick_acc(12, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL vend_cancel_dropped: outputs seen %b expected %b", acc, O_NONE);
    end
    insert_coin = 1'b1;
    tick_acc(5, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL vend_cancel_not_held: outputs seen %b expected %b", acc, O_NONE);
    end
    release_all("vendcan");
    // insert_coin low during debounce, high only at the grant edge
    insert_coin = 1'b0;
    coin50_raw  = 1'b1;
    repeat (6) tick();
    insert_coin = 1'b1;
    tick();
    checks++;
    if (outs() !== O_FIFTY) begin
      failures++;
      $display("FAIL vend_grant_sample: got %b expected %b", outs(), O_FIFTY);
    end
    release_all("vendsample");
    $display("test_coin_while_vending done");
  endtask

  task automatic test_reset_mid();
    logic [3:0] acc;
    insert_coin = 1'b1;
    coin50_raw  = 1'b1;
    repeat (7) tick();
    checks++;
    if (outs() !== O_FIFTY) begin
      failures++;
      $display("FAIL rstmid_pulse: got %b expected %b", outs(), O_FIFTY);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL rstmid_async_clear: got %b expected %b", outs(), O_NONE);
    end
    coin50_raw = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick_acc(12, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL rstmid_idle: outputs seen %b expected %b", acc, O_NONE);
    end
    // Press, then reset with the counter at 2 while raw stays high.
    coin50_raw = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL rstmid_cnt2_clear: got %b expected %b", outs(), O_NONE);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick_acc(6, acc);
    checks++;
    if (acc !== O_NONE) begin
      failures++;
      $display("FAIL rstmid_early: outputs seen %b expected %b", acc, O_NONE);
    end
    tick();
    checks++;
    if (outs() !== O_FIFTY) begin
      failures++;
      $display("FAIL rstmid_repress_pulse: got %b expected %b", outs(), O_FIFTY);
    end
    tick();
    checks++;
    if (outs() !== O_NONE) begin
      failures++;
      $display("FAIL rstmid_repress_end: got %b expected %b", outs(), O_NONE);
    end
    release_all("rstmid");
    $display("test_reset_mid done");
  endtask

  task automatic test_long_hold();
    int         n_pulse;
    logic [3:0] others;
    n_pulse = 0;
    others  = O_NONE;
    coin50_raw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_pulse += int'(fifty);
      others = others | (outs() & ~O_FIFTY);
    end
    checks++;
    if (n_pulse != 1 || others !== O_NONE) begin
      failures++;
      $display("FAIL long_hold: pulses %0d others %b expected 1 and %b", n_pulse, others, O_NONE);
    end
    release_all("long");
    n_pulse = 0;
    coin50_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_pulse += int'(fifty);
    end
    checks++;
    if (n_pulse != 1) begin
      failures++;
      $display("FAIL long_repress: pulses %0d expected 1", n_pulse);
    end
    release_all("longre");
    $display("test_long_hold done");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_coin_while_vending();
    test_reset_mid();
    test_long_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
